// File: rtl/race_sequencer_if.sv
`timescale 1ns/1ps
// Signal bundle between the menu/car logic (master) and the race sequencer (slave).
interface race_sequencer_if;
    logic [2:0]  menu_state;
    logic [3:0]  keyboard_in;
    logic [11:0] player_pos;
    logic [11:0] opponent_pos;
    logic [2:0]  race_state;
    logic [1:0]  lights;
    logic        car_enable;
    logic [13:0] race_time;
    logic [1:0]  winner;
    logic        false_start;
    logic        back_to_main_menu_flag;

    modport master (
        output menu_state, keyboard_in, player_pos, opponent_pos,
        input  race_state, lights, car_enable, race_time, winner, false_start,
               back_to_main_menu_flag
    );

    modport slave (
        input  menu_state, keyboard_in, player_pos, opponent_pos,
        output race_state, lights, car_enable, race_time, winner, false_start,
               back_to_main_menu_flag
    );
endinterface

// File: rtl/race_sequencer.sv
`timescale 1ns/1ps
// Drag-race sequencer: start-light countdown, timed run, winner decision and result hold.
// race_state is the FSM state register itself.
module race_sequencer #(
    parameter int CLK_PER_CS  = 650000,
    parameter int TRACK_LEN   = 3000,
    parameter int RESULT_CS   = 300,
    parameter int MAX_TIME_CS = 9999
) (
    input  logic            clk,
    input  logic            rst,
    race_sequencer_if.slave bus
);
    localparam int PRE_W           = (CLK_PER_CS > 1) ? $clog2(CLK_PER_CS) : 1;
    localparam int STEP_W          = 16;
    localparam int STEPS_PER_LIGHT = 100;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RACE      = 3'd2,
        S_RESULT    = 3'd3
    } state_t;

    state_t            state, state_next;
    logic [PRE_W-1:0]  pre_cnt;
    logic [STEP_W-1:0] step_cnt, step_d;
    logic [2:0]        menu_prev;
    logic              hist_valid;

    logic [1:0]  lights_q, lights_d;
    logic        car_q, car_d;
    logic [13:0] time_q, time_d;
    logic [1:0]  winner_q, winner_d;
    logic        fs_q, fs_d;
    logic        flag_q, flag_d;
    logic        clear_all;

    logic in_game, start_edge, abort, cs_tick, throttle;
    logic p_fin, o_fin, any_fin, light_step, last_light, hold_done, at_max;
    logic unused_keys;

    assign in_game     = (bus.menu_state == 3'd1);
    // No edge can be inferred until one clock of menu history exists after reset.
    assign start_edge  = hist_valid && in_game && (menu_prev != 3'd1);
    assign abort       = !in_game;
    assign cs_tick     = (state != S_IDLE) && (pre_cnt == PRE_W'(CLK_PER_CS - 1));
    assign throttle    = bus.keyboard_in[2];
    assign unused_keys = ^{bus.keyboard_in[3], bus.keyboard_in[1:0]};
    assign p_fin       = (bus.player_pos >= 12'(TRACK_LEN));
    assign o_fin       = (bus.opponent_pos >= 12'(TRACK_LEN));
    assign any_fin     = p_fin || o_fin;
    assign light_step  = cs_tick && (step_cnt == STEP_W'(STEPS_PER_LIGHT - 1));
    assign last_light  = (lights_q == 2'd1);
    assign hold_done   = cs_tick && (step_cnt == STEP_W'(RESULT_CS - 1));
    assign at_max      = (time_q == 14'(MAX_TIME_CS));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic; abort outranks every other exit
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start_edge) state_next = S_COUNTDOWN;
            S_COUNTDOWN: begin
                if (abort)                         state_next = S_IDLE;
                else if (throttle)                 state_next = S_RESULT;
                else if (light_step && last_light) state_next = S_RACE;
            end
            S_RACE: begin
                if (abort)                  state_next = S_IDLE;
                else if (any_fin || at_max) state_next = S_RESULT;
            end
            S_RESULT: begin
                if (abort)          state_next = S_IDLE;
                else if (hold_done) state_next = S_IDLE;
            end
            default:                state_next = S_IDLE;
        endcase
    end

    // Output/datapath next values
    always_comb begin
        lights_d  = lights_q;
        car_d     = car_q;
        time_d    = time_q;
        winner_d  = winner_q;
        fs_d      = fs_q;
        flag_d    = 1'b0;
        step_d    = step_cnt;
        clear_all = 1'b0;
        case (state)
            S_IDLE: begin
                lights_d = 2'd0;
                car_d    = 1'b0;
                step_d   = '0;
                if (start_edge) begin
                    lights_d = 2'd3;
                    time_d   = '0;
                    winner_d = 2'd0;
                    fs_d     = 1'b0;
                end
            end
            S_COUNTDOWN: begin
                if (abort) clear_all = 1'b1;
                else if (throttle) begin
                    fs_d     = 1'b1;
                    winner_d = 2'd2;
                    step_d   = '0;
                end else if (light_step) begin
                    step_d   = '0;
                    lights_d = lights_q - 2'd1;
                    car_d    = last_light;
                end else if (cs_tick) begin
                    step_d = step_cnt + 1'b1;
                end
            end
            S_RACE: begin
                if (abort) clear_all = 1'b1;
                else if (any_fin) begin
                    winner_d = {o_fin, p_fin};
                    car_d    = 1'b0;
                    step_d   = '0;
                end else if (at_max) begin
                    winner_d = 2'd2;
                    car_d    = 1'b0;
                    step_d   = '0;
                end else if (cs_tick) begin
                    time_d = time_q + 1'b1;
                end
            end
            S_RESULT: begin
                car_d = 1'b0;
                if (abort) clear_all = 1'b1;
                else if (hold_done) begin
                    flag_d   = 1'b1;
                    step_d   = '0;
                    lights_d = 2'd0;
                end else if (cs_tick) begin
                    step_d = step_cnt + 1'b1;
                end
            end
            default: clear_all = 1'b1;
        endcase
        if (clear_all) begin
            lights_d = 2'd0;
            car_d    = 1'b0;
            time_d   = '0;
            winner_d = 2'd0;
            fs_d     = 1'b0;
            flag_d   = 1'b0;
            step_d   = '0;
        end
    end

    // Prescaler restarts on every state change so each phase starts on a whole centisecond
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre_cnt <= '0;
        else if ((state_next != state) || (state == S_IDLE) || cs_tick) pre_cnt <= '0;
        else pre_cnt <= pre_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            menu_prev  <= 3'd0;
            hist_valid <= 1'b0;
            step_cnt   <= '0;
            lights_q   <= 2'd0;
            car_q      <= 1'b0;
            time_q     <= '0;
            winner_q   <= 2'd0;
            fs_q       <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            menu_prev  <= bus.menu_state;
            hist_valid <= 1'b1;
            step_cnt   <= step_d;
            lights_q   <= lights_d;
            car_q      <= car_d;
            time_q     <= time_d;
            winner_q   <= winner_d;
            fs_q       <= fs_d;
            flag_q     <= flag_d;
        end
    end

    assign bus.race_state             = state;
    assign bus.lights                 = lights_q;
    assign bus.car_enable             = car_q;
    assign bus.race_time              = time_q;
    assign bus.winner                 = winner_q;
    assign bus.false_start            = fs_q;
    assign bus.back_to_main_menu_flag = flag_q;
endmodule
